// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction: a direct-mapped table of saturating counters,
// read combinationally by fetch and trained by execute, plus a registered flush/redirect.
// Optional performance counters are built only when BPU_PERF_EN is defined.
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_BITS  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic [XLEN-1:0] lookup_addr,
  output logic            lookup_taken,
  input  logic            valid,
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic            taken,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] target,
  output logic            do_flush,
  output logic [XLEN-1:0] redirect_addr,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

  logic [CTR_BITS-1:0] bht [BHT_DEPTH];

  logic [IDX_W-1:0]    lookup_idx;
  logic [IDX_W-1:0]    train_idx;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_next;
  logic                acc;
  logic                br;
  logic                mp;
  logic                jr;
  logic [XLEN-1:0]     redirect_next;
  logic                unused_bits;

  assign lookup_idx   = lookup_addr[IDX_W+1:2];
  assign train_idx    = branch_pc[IDX_W+1:2];
  assign lookup_taken = bht[lookup_idx][CTR_BITS-1];
  assign unused_bits  = ^{lookup_addr[XLEN-1:IDX_W+2], lookup_addr[1:0]};

  // Resolve port has valid only (no ready): a resolve is taken whenever valid is
  // high, the pipe is not stalled, and we are not in the squash cycle of a flush.
  assign acc = valid & ~stall & ~do_flush;
  assign jr  = acc & is_jump;
  assign br  = acc & is_branch & ~is_jump;
  assign mp  = br & (taken != pred_taken);

  assign redirect_next = (is_jump | (is_branch & taken)) ? target : branch_pc + XLEN'(4);

  assign ctr_cur = bht[train_idx];
  always_comb begin
    ctr_next = ctr_cur;
    if (taken) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_BITS'(1);
    end else begin
      if (ctr_cur != '0) ctr_next = ctr_cur - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
    end else if (br) begin
      bht[train_idx] <= ctr_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      do_flush      <= 1'b0;
      redirect_addr <= '0;
    end else if (!stall) begin
      do_flush <= mp | jr;
      if (mp | jr) redirect_addr <= redirect_next;
    end
  end

`ifdef BPU_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (br) branch_count     <= branch_count + 32'd1;
      if (mp) mispredict_count <= mispredict_count + 32'd1;
    end
  end
`else
  assign branch_count     = 32'd0;
  assign mispredict_count = 32'd0;
`endif

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction block for the execute stage of the RISC-V pipeline. It replaces the always-not-taken redirect scheme with a direct-mapped table of saturating counters. The fetch stage reads the table to predict conditional branches. The execute stage reports each resolved control-flow instruction. The unit compares the outcome against the prediction, trains the table, and issues a registered flush with a redirect address.

## Interface
- XLEN, 32, datapath/address width.
- BHT_DEPTH, 64, counter-table entries; power of two, ≥ 2.
- CTR_BITS, 2, counter width; ≥ 2.
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  freezes all sequential state.
- lookup_addr  in  XLEN  fetch PC to predict.
- lookup_taken  out  1  combinational prediction: MSB of the indexed counter.
- valid  in  1  resolve inputs are meaningful.
- is_branch  in  1  conditional branch.
- is_jump  in  1  jal or jalr.
- taken  in  1  actual branch outcome from the comparator.
- pred_taken  in  1  prediction carried down the pipe from fetch.
- branch_pc  in  XLEN  PC of the resolving instruction.
- target  in  XLEN  computed target (imm-relative or jalr sum).
- do_flush  out  1  registered redirect pulse.
- redirect_addr  out  XLEN  registered redirect PC; meaningful while do_flush = 1.
- branch_count  out  32  resolved conditional branches (see Configuration).
- mispredict_count  out  32  conditional mispredicts (see Configuration).

## Operation
- Index: idx = PC[$clog2(BHT_DEPTH)+1 : 2]. Bits [1:0] are ignored.
- Accepted resolve: acc = valid & ~stall & ~do_flush. While do_flush = 1, inputs belong to a squashed instruction and are ignored.
- Mispredict: mp = acc & is_branch & (taken ≠ pred_taken).
- Jumps: jr = acc & is_jump. A jump always redirects.
- Redirect address:
  - target when jr, or when is_branch & taken;
  - otherwise branch_pc + 4, modulo 2^XLEN.
- Training: on acc & is_branch, counter[idx(branch_pc)] saturates up if taken, down if not.
  - Saturation bounds are 0 and 2^CTR_BITS − 1.
  - Jumps do not train.
- is_branch & is_jump both high is illegal; is_jump takes priority, and no training occurs.
- Lookup reads the stored value. A same-cycle update to the same index is not bypassed: lookup returns the pre-update value.
- Reset values:
  - every counter = 2^(CTR_BITS−1) − 1 (weakly not-taken; 01 for CTR_BITS = 2);
  - do_flush = 0;
  - redirect_addr = 0;
  - counts = 0.

## Timing
- Lookup: zero-cycle combinational path from lookup_addr to lookup_taken.
- Resolve to flush: one cycle. The edge sampling mp | jr sets do_flush = 1 and redirect_addr for the following cycle.
- do_flush is a single-cycle pulse. It clears on the next unstalled edge, because inputs during the flush cycle are ignored. Back-to-back flushes are therefore impossible.
- stall = 1: no training, and do_flush, redirect_addr and the counts hold their values. A pending flush persists until the first unstalled edge after it.
- Table updates are visible to lookup on the cycle after the training edge.
- Asynchronous reset mid-operation immediately forces the reset values, including dropping an in-flight do_flush. The first accepted resolve after reset release trains normally.

## Configuration
- BPU_PERF_EN defined: branch_count increments on acc & is_branch, and mispredict_count increments on mp.
  - Both wrap at 2^32.
  - Both hold under stall.
  - Both reset to 0.
- BPU_PERF_EN undefined: both ports are present and tied to 0, and no counter registers are synthesised.

## Test plan
- Reset then lookup_addr = 0x100 -> lookup_taken = 0. A branch at 0x100 with pred_taken = 0, taken = 1, target = 0x40 -> next cycle do_flush = 1, redirect_addr = 0x40. The cycle after, do_flush = 0 and lookup_taken(0x100) = 1.
- Train the same branch taken 5 times, then not-taken once -> counter reads 3 then 2, and lookup_taken stays 1. That not-taken resolve with pred_taken = 1 redirects to 0x104.
- jal at 0x200, target = 0x800, pred_taken = 0 -> flush to 0x800, table unchanged. With valid high during the flush cycle -> input ignored, no second flush.
- Mispredict with stall = 1 for 3 cycles -> no flush and no training. Release stall -> flush on the following cycle.
- branch_pc = 0xFFFFFFFC, not-taken, pred_taken = 1 -> redirect_addr = 0x00000000 (wrap). Assert reset while do_flush = 1 -> do_flush = 0 immediately and all counters return to 01.
- BPU_PERF_EN defined: 10 branches with 3 mispredicts -> branch_count = 10, mispredict_count = 3. BPU_PERF_EN undefined: both outputs read 0.
